int_request_ctrl: RTL
=====================

// Module: int_request_ctrl
// PURPOSE
//  Device-side interrupt request controller feeding the CPU's 32-line INT32 bus.
//  - Synchronises raw device IRQs and latches edge or level events into a pending register.
//  - Drives pending onto INT32 for the CPU interrupt priority logic.
//  - Clears pending on the CPU acknowledge, which carries the cause word (index<<2).
//  - Tracks in-service sources and retires the highest-priority one on ERET.
// PARAMETERS
//  NSRC         32  number of interrupt sources, 1..32; INT32 bits >= NSRC are tied to 0
//  SYNC_STAGES  2   flops in each raw-IRQ synchroniser, >= 2
// PORTS
//  clk          in   1     system clock, single clock domain
//  rst_n        in   1     asynchronous reset, active low
//  irq_raw      in   NSRC  device requests, asynchronous to clk
//  edge_mode    in   NSRC  per source: 1 = rising-edge triggered, 0 = level triggered
//  ack_valid    in   1     one-cycle pulse: CPU has taken an interrupt
//  ack_cause    in   32    cause word from the CPU; index = ack_cause[6:2]
//  eret         in   1     one-cycle pulse: CPU returns from the current handler
//  ovr_clr      in   NSRC  write-1-to-clear for the overrun flags
//  INT32        out  32    pending requests to the CPU, registered
//  inservice    out  NSRC  sources currently being serviced
//  overrun      out  NSRC  sticky: an edge arrived while that source was already pending
//  ack_err      out  1     one-cycle pulse: malformed or out-of-range acknowledge
// BEHAVIOUR
//  Reset (async, rst_n=0)
//  - All synchroniser flops, pending, inservice and overrun clear to 0; ack_err = 0.
//  - Reset mid-operation discards every pending and in-service event.
//  - First edge detection after reset compares against 0, so a source that is already
//    high at release counts as one rising edge.
//  Synchronisation and edge detection
//  - s[i] = irq_raw[i] after SYNC_STAGES flops; edge[i] = s[i] & ~s_d[i].
//  Pending, edge sources
//  - Set on edge[i].
//  - Cleared on a valid ack whose index is i.
//  - Edge and ack for i in the same cycle: pending stays 1, because set wins.
//  - edge[i] while pending[i] is already 1 sets overrun[i]; no count is kept.
//  Pending, level sources
//  - pending[i] = s[i] every cycle; ack has no effect on it. The device must deassert.
//  Acknowledge
//  - Valid when ack_valid=1, ack_cause[1:0]==0, ack_cause[31:7]==0 and index < NSRC.
//  - Valid ack: inservice[index] is set next cycle.
//  - Otherwise: ack_err pulses for 1 cycle and no state changes. This covers the CPU's
//    catch-all cause 19 when NSRC <= 19.
//  ERET
//  - Clears the lowest-index set bit of inservice (isolate with x & (~x+1), the same
//    priority rule the CPU uses).
//  - inservice == 0: no effect.
//  - ack_valid and eret in the same cycle: apply ERET first, then ACK, so a
//    back-to-back nested entry keeps its bit.
//  Overrun clear
//  - ovr_clr[i] clears overrun[i].
//  - A new overrun event in the same cycle wins.
//  Latency
//  - irq_raw edge -> INT32 bit high: SYNC_STAGES+1 clk.
//  - Valid ack -> INT32 bit low: 1 clk.
//  - INT32 = zero-extended pending, driven straight from a flop.
// STRUCTURE
//  - Shared package int_pkg:
//    - INT_W = 32
//    - CAUSE_IDX_LSB = 2, CAUSE_IDX_MSB = 6
//    - function cause_to_idx
//    - function lowest_set (one-hot isolate)
//  - Sub-module irq_sync: a SYNC_STAGES-deep single-bit synchroniser plus edge detector,
//    instantiated NSRC times in a generate loop.
//  - Top level holds the pending, inservice and overrun vectors and the ack decode.
// TESTING
//  1. Reset: assert rst_n=0 mid-stream -> INT32, inservice, overrun and ack_err all 0
//     immediately, without waiting for a clock edge.
//  2. Edge source 3 pulses high -> INT32=32'h8 after 3 clk.
//     Then ack_cause=32'hC -> INT32=0 next clk and inservice=8.
//  3. Level source 5 held high -> ack_cause=32'h14 leaves INT32[5]=1.
//     Drop irq_raw[5] -> INT32[5]=0 after 3 clk.
//  4. Source 2 edges twice before any ack -> overrun[2]=1.
//     ovr_clr[2]=1 -> overrun[2]=0.
//  5. inservice=32'h24, eret -> inservice=32'h20; eret again -> 0; eret again -> no change.
//  6. Malformed and colliding acks:
//     - ack_cause=32'h4C (index 19) with NSRC=16 -> ack_err 1-clk pulse, state unchanged.
//     - ack_cause=32'h5 -> ack_err pulse.
//     - Edge and ack for source 1 in the same cycle -> INT32[1] stays 1.

Source files
------------

// File: rtl/int_request_ctrl_pkg.sv
// Shared definitions for the interrupt request controller.
//   INT_W          width of the CPU interrupt bus and of the cause word
//   CAUSE_IDX_*    location of the source index within the cause word
//   cause_to_idx   extracts the source index from a cause word
//   lowest_set     isolates the lowest set bit (the CPU's priority rule)
package int_pkg;

   localparam int unsigned INT_W         = 32;
   localparam int unsigned CAUSE_IDX_LSB = 2;
   localparam int unsigned CAUSE_IDX_MSB = 6;
   localparam int unsigned IDX_W         = CAUSE_IDX_MSB - CAUSE_IDX_LSB + 1;

   function automatic logic [IDX_W-1:0] cause_to_idx(input logic [INT_W-1:0] cause);
      return cause[CAUSE_IDX_MSB:CAUSE_IDX_LSB];
   endfunction

   function automatic logic [INT_W-1:0] lowest_set(input logic [INT_W-1:0] x);
      return x & (~x + INT_W'(1));
   endfunction

endpackage

// File: rtl/int_request_ctrl_if.sv
// CPU-side interrupt bus between the CPU and int_request_ctrl.
//   ack_valid  CPU -> ctrl  one-cycle acknowledge pulse
//   ack_cause  CPU -> ctrl  cause word, index in bits [6:2]
//   eret       CPU -> ctrl  one-cycle return-from-handler pulse
//   INT32      ctrl -> CPU  registered pending requests
//   ack_err    ctrl -> CPU  one-cycle malformed-acknowledge pulse
interface int_request_ctrl_if;
   import int_pkg::*;

   logic             ack_valid;
   logic [INT_W-1:0] ack_cause;
   logic             eret;
   logic [INT_W-1:0] INT32;
   logic             ack_err;

   modport master (output ack_valid, ack_cause, eret, input INT32, ack_err);
   modport slave  (input ack_valid, ack_cause, eret, output INT32, ack_err);

endinterface

// File: rtl/int_request_ctrl_sync.sv
// irq_sync: SYNC_STAGES-deep single-bit synchroniser plus rising-edge detector.
//   clk, rst_n  clock and async active-low reset
//   d           asynchronous raw request
//   s           synchronised level
//   edge_det    high for one cycle after s rises (reset history is 0)
module irq_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic s,
   output logic edge_det
);

   logic [SYNC_STAGES-1:0] ff;
   logic                   s_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff  <= '0;
         s_d <= 1'b0;
      end else begin
         ff  <= {ff[SYNC_STAGES-2:0], d};
         s_d <= ff[SYNC_STAGES-1];
      end
   end

   assign s        = ff[SYNC_STAGES-1];
   assign edge_det = s & ~s_d;

endmodule

// File: rtl/int_request_ctrl.sv
// int_request_ctrl: device-side interrupt request controller.
//   clk, rst_n  clock and async active-low reset
//   irq_raw     asynchronous device requests
//   edge_mode   per source: 1 = rising-edge, 0 = level triggered
//   ovr_clr     write-1-to-clear for overrun
//   cpu         CPU interrupt bus (ack, eret, INT32, ack_err)
//   inservice   sources currently being serviced
//   overrun     sticky: edge arrived while already pending
module int_request_ctrl
   import int_pkg::*;
#(
   parameter int unsigned NSRC        = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NSRC-1:0]      irq_raw,
   input  logic [NSRC-1:0]      edge_mode,
   input  logic [NSRC-1:0]      ovr_clr,
   int_request_ctrl_if.slave    cpu,
   output logic [NSRC-1:0]      inservice,
   output logic [NSRC-1:0]      overrun
);

   logic [NSRC-1:0]  s_vec;
   logic [NSRC-1:0]  edges;
   logic [NSRC-1:0]  pending;
   logic [NSRC-1:0]  ack_hot;
   logic [NSRC-1:0]  pend_nxt;
   logic [NSRC-1:0]  ovr_nxt;
   logic [NSRC-1:0]  isv_nxt;
   logic [INT_W-1:0] isv_after_eret;
   logic [IDX_W-1:0] ack_idx;
   logic             ack_ok;
   logic             ack_err_nxt;

   for (genvar i = 0; i < NSRC; i++) begin : g_sync
      irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk      (clk),
         .rst_n    (rst_n),
         .d        (irq_raw[i]),
         .s        (s_vec[i]),
         .edge_det (edges[i])
      );
   end

   always_comb begin
      ack_idx     = cause_to_idx(cpu.ack_cause);
      ack_ok      = cpu.ack_valid
                    && (cpu.ack_cause[CAUSE_IDX_LSB-1:0] == '0)
                    && (cpu.ack_cause[INT_W-1:CAUSE_IDX_MSB+1] == '0)
                    && (INT_W'(ack_idx) < NSRC);
      ack_err_nxt = cpu.ack_valid && !ack_ok;
      ack_hot     = ack_ok ? NSRC'(INT_W'(1) << ack_idx) : '0;

      // Edge sources: set beats ack-clear. Level sources simply follow s.
      pend_nxt = (edge_mode & (edges | (pending & ~ack_hot))) | (~edge_mode & s_vec);
      // New overrun event beats the clear.
      ovr_nxt  = (edge_mode & edges & pending) | (overrun & ~ovr_clr);

      // ERET retires the lowest index first, then a same-cycle ack re-enters.
      isv_after_eret = INT_W'(inservice);
      if (cpu.eret) begin
         isv_after_eret = isv_after_eret & ~lowest_set(isv_after_eret);
      end
      isv_nxt = isv_after_eret[NSRC-1:0] | ack_hot;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         inservice   <= '0;
         overrun     <= '0;
         cpu.ack_err <= 1'b0;
      end else begin
         pending     <= pend_nxt;
         inservice   <= isv_nxt;
         overrun     <= ovr_nxt;
         cpu.ack_err <= ack_err_nxt;
      end
   end

   assign cpu.INT32 = INT_W'(pending);

endmodule
